// File: rtl/seg_disp_sched.sv
// seg_disp_sched
//   Shares one 4-digit seven-segment display between two round-robin
//   normal sources and one pre-emptive alarm source. The outputs feed the
//   dynamic display driver directly.
// Ports:
//   sys_clk, sys_rst_n          clock, async active-low reset
//   req0/1/2                    level requests (req2 = alarm)
//   data0/1/2 [13:0]            binary value per source
//   point0/1/2 [3:0]            decimal-point mask per source
//   gnt [2:0]                   one-hot owner (registered decode of state)
//   data_out [13:0]             granted value clamped to 9999 (one cycle after gnt)
//   point_out [3:0]             granted point mask (one cycle after gnt)
//   seg_en                      high while any source owns the display
//   ovf                         granted value was clamped
module seg_disp_sched #(
    parameter int CLK_PER_MS = 100_000,
    parameter int DWELL_MS   = 2000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        req2,
    input  logic [13:0] data0,
    input  logic [13:0] data1,
    input  logic [13:0] data2,
    input  logic [3:0]  point0,
    input  logic [3:0]  point1,
    input  logic [3:0]  point2,
    output logic [2:0]  gnt,
    output logic [13:0] data_out,
    output logic [3:0]  point_out,
    output logic        seg_en,
    output logic        ovf
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW0 = 2'd1;
    localparam logic [1:0] ST_SHOW1 = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int DW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_PER_MS - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_MS - 1);
    localparam logic [13:0]   MAX_VAL   = 14'd9999;

    logic [1:0]    state, state_nxt;
    logic          last;           // last normal source served
    logic [PW-1:0] pre_cnt;
    logic [DW-1:0] dwell_cnt;
    logic          tick, dwell_done;

    assign tick       = (pre_cnt == PRE_MAX);
    assign dwell_done = tick && (dwell_cnt == DWELL_MAX);

    always_comb begin
        state_nxt = state;
        if (state != ST_ALARM && req2) begin
            state_nxt = ST_ALARM;
        end else begin
            case (state)
                ST_ALARM: if (!req2) state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (req0 && req1)
                        state_nxt = last ? ST_SHOW0 : ST_SHOW1;
                    else if (req0)
                        state_nxt = ST_SHOW0;
                    else if (req1)
                        state_nxt = ST_SHOW1;
                end
                ST_SHOW0: begin
                    // A release wins over dwell expiry in the same cycle.
                    if (!req0)
                        state_nxt = req1 ? ST_SHOW1 : ST_IDLE;
                    else if (dwell_done && req1)
                        state_nxt = ST_SHOW1;
                end
                ST_SHOW1: begin
                    if (!req1)
                        state_nxt = req0 ? ST_SHOW0 : ST_IDLE;
                    else if (dwell_done && req0)
                        state_nxt = ST_SHOW0;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            pre_cnt   <= '0;
            dwell_cnt <= '0;
            gnt       <= 3'b000;
        end else begin
            state <= state_nxt;
            case (state_nxt)
                ST_SHOW0: gnt <= 3'b001;
                ST_SHOW1: gnt <= 3'b010;
                ST_ALARM: gnt <= 3'b100;
                default:  gnt <= 3'b000;
            endcase
            if (state_nxt != state) begin
                pre_cnt   <= '0;
                dwell_cnt <= '0;
                if (state_nxt == ST_SHOW0) last <= 1'b0;
                if (state_nxt == ST_SHOW1) last <= 1'b1;
            end else if (tick) begin
                // Wraps on dwell_done, so a lone requester simply restarts its dwell.
                pre_cnt   <= '0;
                dwell_cnt <= dwell_done ? '0 : dwell_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Live source mux; registered below so outputs lag gnt by one cycle.
    logic [13:0] sel_data;
    logic [3:0]  sel_point;

    always_comb begin
        sel_data  = '0;
        sel_point = '0;
        case (state)
            ST_SHOW0: begin sel_data = data0; sel_point = point0; end
            ST_SHOW1: begin sel_data = data1; sel_point = point1; end
            ST_ALARM: begin sel_data = data2; sel_point = point2; end
            default:  ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_out  <= '0;
            point_out <= '0;
            seg_en    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            data_out  <= (sel_data > MAX_VAL) ? MAX_VAL : sel_data;
            ovf       <= (sel_data > MAX_VAL);
            point_out <= sel_point;
            seg_en    <= (state != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_seg_disp_sched.sv
module tb_seg_disp_sched;
    localparam int CPM   = 4;
    localparam int DWM   = 3;
    localparam int DWELL = CPM * DWM;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, req2 = 0;
    logic [13:0] data0 = 0, data1 = 0, data2 = 0;
    logic [3:0]  point0 = 0, point1 = 0, point2 = 0;
    logic [2:0]  gnt;
    logic [13:0] data_out;
    logic [3:0]  point_out;
    logic        seg_en, ovf;

    seg_disp_sched #(.CLK_PER_MS(CPM), .DWELL_MS(DWM)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req0(req0), .req1(req1), .req2(req2),
        .data0(data0), .data1(data1), .data2(data2),
        .point0(point0), .point1(point1), .point2(point2),
        .gnt(gnt), .data_out(data_out), .point_out(point_out),
        .seg_en(seg_en), .ovf(ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: owner (-1 idle, 0/1 normal, 2 alarm), cycles spent
    // with the current owner, and the last normal source served.
    int owner, last_src, elapsed;
    logic [2:0]  e_gnt;
    logic [13:0] e_data;
    logic [3:0]  e_pt;
    logic        e_seg, e_ovf;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("data_out", 32'(data_out), 32'(e_data));
        chk("point_out", 32'(point_out), 32'(e_pt));
        chk("seg_en", 32'(seg_en), 32'(e_seg));
        chk("ovf", 32'(ovf), 32'(e_ovf));
    endtask

    task automatic model_reset();
        owner = -1; last_src = 1; elapsed = 0;
        e_gnt = 0; e_data = 0; e_pt = 0; e_seg = 0; e_ovf = 0;
    endtask

    function automatic int next_owner(int o, bit r0, bit r1, bit r2, bit done);
        bit mine, other;
        if (o == 2) return r2 ? 2 : -1;
        if (r2) return 2;
        if (o == -1) begin
            if (r0 && r1) return (last_src == 0) ? 1 : 0;
            if (r0) return 0;
            if (r1) return 1;
            return -1;
        end
        mine  = (o == 0) ? r0 : r1;
        other = (o == 0) ? r1 : r0;
        if (!mine) return other ? 1 - o : -1;
        if (done && other) return 1 - o;
        return o;
    endfunction

    task automatic step();
        int no, d;
        logic [3:0] p;
        no = next_owner(owner, req0, req1, req2, elapsed == DWELL - 1);
        case (owner)
            0: begin d = int'(data0); p = point0; end
            1: begin d = int'(data1); p = point1; end
            2: begin d = int'(data2); p = point2; end
            default: begin d = 0; p = 0; end
        endcase
        @(posedge sys_clk); #1;
        e_data = 14'((d > 9999) ? 9999 : d);
        e_ovf  = (d > 9999);
        e_pt   = p;
        e_seg  = (owner != -1);
        e_gnt  = (no < 0) ? 3'b000 : 3'(1 << no);
        if (no != owner) begin
            elapsed = 0;
            if (no == 0 || no == 1) last_src = no;
        end else begin
            elapsed = (elapsed + 1) % DWELL;
        end
        owner = no;
        check_all();
    endtask

    task automatic wait_owner(input int o, input int e);
        for (int i = 0; i < 100 && !(owner == o && elapsed == e); i++) step();
        chk("wait_owner", 32'(owner == o && elapsed == e), 32'd1);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    function automatic logic [13:0] rnd_val();
        case ($urandom_range(0, 4))
            0: return 14'd9999;
            1: return 14'd10000;
            2: return 14'd16383;
            3: return 14'd9998;
            default: return 14'($urandom_range(0, 16383));
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check_all();
        sys_rst_n = 1'b1;

        // Round-robin between the two normal sources
        req0 = 1; req1 = 1; data0 = 14'd1234; data1 = 14'd42;
        point0 = 4'b0001; point1 = 4'b0010;
        step();
        chk("rr_first", 32'(gnt), 32'b001);
        repeat (40) step();

        // Alarm pre-emption mid-dwell
        wait_owner(0, 5);
        req2 = 1; data2 = 14'd7777; point2 = 4'b0100;
        step();
        chk("alarm_gnt", 32'(gnt), 32'b100);
        step();
        chk("alarm_data", 32'(data_out), 32'd7777);
        chk("alarm_pt", 32'(point_out), 32'b0100);
        repeat (3) step();
        req2 = 0;
        step();
        chk("alarm_idle", 32'(gnt), 32'b000);
        step();
        chk("post_alarm_gnt", 32'(gnt), 32'b010);
        chk("post_alarm_seg", 32'(seg_en), 32'd0);

        // Early release
        req0 = 0;
        wait_owner(1, 2);
        req1 = 0;
        step();
        chk("rel_gnt", 32'(gnt), 32'b000);
        step();
        chk("rel_seg", 32'(seg_en), 32'd0);

        // Clamp boundary
        req0 = 1; data0 = 14'd12000;
        repeat (2) step();
        chk("clamp_data", 32'(data_out), 32'd9999);
        chk("clamp_ovf", 32'(ovf), 32'd1);
        data0 = 14'd9999;
        step();
        chk("edge_ovf", 32'(ovf), 32'd0);
        data0 = 14'd16383;
        step();
        chk("max_ovf", 32'(ovf), 32'd1);

        // Sole requester across several dwell expiries
        repeat (40) begin
            step();
            chk("sole_seg", 32'(seg_en), 32'd1);
        end

        // Reset mid-SHOW1, then source 0 first again
        req0 = 0; req1 = 1;
        wait_owner(1, 4);
        do_reset();
        req0 = 1; req1 = 1;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'b001);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            if ($urandom_range(0, 29) == 0) req2 = ~req2;
            if ($urandom_range(0, 3) == 0) data0 = rnd_val();
            if ($urandom_range(0, 3) == 0) data1 = rnd_val();
            if ($urandom_range(0, 3) == 0) data2 = rnd_val();
            if ($urandom_range(0, 5) == 0) point0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) point1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) point2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
